// File: rtl/div_sched_pkg.sv
// Shared types and constants for the divider sequencer.
package div_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_LAUNCH,
    ST_RUN,
    ST_RESP
  } state_e;

  localparam logic [31:0] DZ_QUOTIENT     = 32'hFFFF_FFFF;
  localparam int          DEFAULT_TIMEOUT = 48;

endpackage

// File: rtl/div_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] next_ptr
);

  logic found;

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    grant    = '0;
    next_ptr = ptr;
    found    = 1'b0;
    // First pass covers ptr..N-1, second pass wraps around to 0..ptr-1.
    for (int i = 0; i < N; i++) begin
      if (!found && (i >= int'(ptr)) && req[i]) begin
        grant[i] = 1'b1;
        next_ptr = (i == N - 1) ? '0 : PW'(i + 1);
        found    = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && (i < int'(ptr)) && req[i]) begin
        grant[i] = 1'b1;
        next_ptr = (i == N - 1) ? '0 : PW'(i + 1);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_sched.sv
// Shares one iterative signed divider among N_REQ requesters, round-robin,
// with divide-by-zero bypass and a watchdog on the divider's busy signal.
module div_sched
  import div_sched_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int IDW     = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [32*N_REQ-1:0]   req_dividend,
  input  logic [32*N_REQ-1:0]   req_divisor,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [IDW-1:0]        resp_id,
  output logic [31:0]           resp_q,
  output logic [31:0]           resp_r,
  output logic                  resp_dz,
  output logic                  resp_err,
  output logic [31:0]           div_dividend,
  output logic [31:0]           div_divisor,
  output logic                  div_start,
  input  logic                  div_busy,
  input  logic [31:0]           div_q,
  input  logic [31:0]           div_r
);

  localparam int PW  = $clog2(N_REQ);
  localparam int WDW = $clog2(TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d, next_ptr;
  logic [WDW-1:0]   wdog_q, wdog_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [31:0]      q_q, q_d, r_q, r_d;
  logic [31:0]      dvd_q, dvd_d, dvs_q, dvs_d;
  logic             dz_q, dz_d, err_q, err_d;
  logic [N_REQ-1:0] grant;
  logic [PW-1:0]    gnt_idx;
  logic [31:0]      sel_dvd, sel_dvs;

  rr_arbiter #(.N(N_REQ), .PW(PW)) u_arb (
    .req      (req_valid),
    .ptr      (ptr_q),
    .grant    (grant),
    .next_ptr (next_ptr)
  );

  always_comb begin
    gnt_idx = '0;
    sel_dvd = '0;
    sel_dvs = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        gnt_idx = PW'(i);
        sel_dvd = req_dividend[32*i +: 32];
        sel_dvs = req_divisor[32*i +: 32];
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      wdog_q  <= '0;
      id_q    <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      dz_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      wdog_q  <= wdog_d;
      id_q    <= id_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      dz_q    <= dz_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wdog_d  = wdog_q;
    id_d    = id_q;
    q_d     = q_q;
    r_d     = r_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    dz_d    = dz_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          ptr_d = next_ptr;
          id_d  = IDW'(gnt_idx);
          dvd_d = sel_dvd;
          dvs_d = sel_dvs;
          err_d = 1'b0;
          // A zero divisor is answered directly; the divider never starts.
          if (sel_dvs == '0) begin
            q_d     = DZ_QUOTIENT;
            r_d     = sel_dvd;
            dz_d    = 1'b1;
            state_d = ST_RESP;
          end else begin
            dz_d    = 1'b0;
            state_d = ST_START;
          end
        end
      end
      ST_START:  state_d = ST_LAUNCH;
      ST_LAUNCH: begin
        wdog_d  = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        wdog_d = wdog_q + 1'b1;
        if (!div_busy) begin
          q_d     = div_q;
          r_d     = div_r;
          dz_d    = 1'b0;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (wdog_d == WDW'(TIMEOUT)) begin
          q_d     = '0;
          r_d     = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: if (resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = '0;
    div_start  = 1'b0;
    resp_valid = 1'b0;
    unique case (state_q)
      ST_IDLE:  if (reset_n) req_ready = grant;
      ST_START: div_start = 1'b1;
      ST_RESP:  resp_valid = 1'b1;
      default:  ;
    endcase
  end

  assign resp_id      = id_q;
  assign resp_q       = q_q;
  assign resp_r       = r_q;
  assign resp_dz      = dz_q;
  assign resp_err     = err_q;
  assign div_dividend = dvd_q;
  assign div_divisor  = dvs_q;

endmodule

// File: tb/tb_div_sched.sv
// Randomized bench for div_sched: a behavioural 32-cycle divider stub plus a
// transaction-level reference model (RR order, signed division, latency).
module tb_div_sched;

  localparam int N_REQ   = 2;
  localparam int TIMEOUT = 48;
  localparam int IDW     = 2;

  logic                clock = 1'b0;
  logic                reset_n = 1'b0;
  logic [N_REQ-1:0]    req_valid = '0;
  logic [N_REQ-1:0]    req_ready;
  logic [32*N_REQ-1:0] req_dividend = '0;
  logic [32*N_REQ-1:0] req_divisor = '0;
  logic                resp_valid;
  logic                resp_ready = 1'b0;
  logic [IDW-1:0]      resp_id;
  logic [31:0]         resp_q, resp_r;
  logic                resp_dz, resp_err;
  logic [31:0]         div_dividend, div_divisor;
  logic                div_start;
  logic                div_busy;
  logic [31:0]         div_q, div_r;

  always #5 clock = ~clock;

  div_sched #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT), .IDW(IDW)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_dividend (req_dividend),
    .req_divisor  (req_divisor),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_id      (resp_id),
    .resp_q       (resp_q),
    .resp_r       (resp_r),
    .resp_dz      (resp_dz),
    .resp_err     (resp_err),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_start    (div_start),
    .div_busy     (div_busy),
    .div_q        (div_q),
    .div_r        (div_r)
  );

  // Divider stub: latches on falling start, busy for 32 cycles; reset from ~reset_n.
  logic        div_rst, st_prev, busy_i, stuck = 1'b0;
  int          dcnt;
  logic [31:0] dq, dr;
  assign div_rst  = ~reset_n;
  assign div_busy = busy_i | stuck;
  assign div_q    = dq;
  assign div_r    = dr;

  always @(posedge clock or posedge div_rst) begin
    if (div_rst) begin
      st_prev <= 1'b0; busy_i <= 1'b0; dcnt <= 0; dq <= '0; dr <= '0;
    end else begin
      st_prev <= div_start;
      if (st_prev && !div_start) begin
        busy_i <= 1'b1;
        dcnt   <= 32;
        if (div_dividend == 32'h8000_0000 && div_divisor == 32'hFFFF_FFFF) begin
          dq <= 32'h8000_0000; dr <= '0;
        end else if (div_divisor != '0) begin
          dq <= $signed(div_dividend) / $signed(div_divisor);
          dr <= $signed(div_dividend) % $signed(div_divisor);
        end
      end else if (busy_i) begin
        dcnt <= dcnt - 1;
        if (dcnt == 1) busy_i <= 1'b0;
      end
    end
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, wanted %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: sign-magnitude long division, quotient truncated toward zero.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic dz);
    longint sa, sb, ua, ub, uq, ur;
    if (b == '0) begin
      q = 32'hFFFF_FFFF; r = a; dz = 1'b1;
      return;
    end
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = (sa < 0) ? -sa : sa;
    ub = (sb < 0) ? -sb : sb;
    uq = ua / ub;
    ur = ua % ub;
    q  = 32'(((sa < 0) != (sb < 0)) ? -uq : uq);
    r  = 32'((sa < 0) ? -ur : ur);
    dz = 1'b0;
  endfunction

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  op_t         ops[$];
  int          served[$];
  logic [31:0] cur_a[N_REQ];
  logic [31:0] cur_b[N_REQ];
  logic [N_REQ-1:0] reload = '0;

  logic        outstanding = 1'b0, rsp_seen = 1'b0, done_pending = 1'b0;
  int          wait_left = 0, hold_cfg = 0, mptr = 0, acc_cyc = 0, starts = 0;
  int          e_id, e_lat;
  logic [31:0] e_a, e_b, e_q, e_r;
  logic        e_dz, e_err;

  task automatic load_reqs();
    for (int i = 0; i < N_REQ; i++) begin
      if (reload[i] || !req_valid[i]) begin
        int idx;
        idx = -1;
        reload[i] = 1'b0;
        foreach (ops[k]) if (idx < 0 && ops[k].id == i) idx = k;
        if (idx >= 0) begin
          cur_a[i] = ops[idx].a;
          cur_b[i] = ops[idx].b;
          ops.delete(idx);
          req_valid[i] = 1'b1;
        end else begin
          req_valid[i] = 1'b0;
        end
        req_dividend[32*i +: 32] = cur_a[i];
        req_divisor[32*i +: 32]  = cur_b[i];
      end
    end
  endtask

  task automatic accept(input int g);
    e_id = g;
    e_a  = cur_a[g];
    e_b  = cur_b[g];
    ref_div(e_a, e_b, e_q, e_r, e_dz);
    e_err = !e_dz && stuck;
    if (e_err) begin e_q = '0; e_r = '0; end
    e_lat       = e_dz ? 0 : (e_err ? 2 + TIMEOUT : 35);
    starts      = 0;
    acc_cyc     = cyc + 1;
    mptr        = (g + 1) % N_REQ;
    reload[g]   = 1'b1;
    outstanding = 1'b1;
  endtask

  // One step per falling edge: drive requesters/resp_ready and compare against the model.
  task automatic agent_step();
    if (!reset_n) begin
      outstanding = 1'b0; done_pending = 1'b0; rsp_seen = 1'b0;
      resp_ready = 1'b0; mptr = 0; reload = '0;
      load_reqs();
      return;
    end
    if (done_pending) begin
      done_pending = 1'b0; outstanding = 1'b0; rsp_seen = 1'b0; resp_ready = 1'b0;
    end
    load_reqs();
    #1;
    if (div_start) starts++;
    if (outstanding) begin
      check("busy_req_ready", 32'(req_ready), 32'(0));
      check("div_dividend", div_dividend, e_a);
      check("div_divisor", div_divisor, e_b);
      if (resp_valid) begin
        if (!rsp_seen) begin
          rsp_seen = 1'b1;
          check("latency", 32'(cyc - acc_cyc), 32'(e_lat));
          check("start_pulses", 32'(starts), e_dz ? 32'(0) : 32'(1));
          wait_left = (hold_cfg >= 0) ? hold_cfg : int'($urandom_range(0, 3));
          served.push_back(e_id);
        end
        check("resp_id", 32'(resp_id), 32'(e_id));
        check("resp_q", resp_q, e_q);
        check("resp_r", resp_r, e_r);
        check("resp_dz", 32'(resp_dz), 32'(e_dz));
        check("resp_err", 32'(resp_err), 32'(e_err));
        if (wait_left > 0) begin
          resp_ready = 1'b0;
          wait_left--;
        end else begin
          resp_ready   = 1'b1;
          done_pending = 1'b1;
        end
      end
    end else begin
      int g, ag;
      logic [N_REQ-1:0] exp_rdy;
      check("idle_resp_valid", 32'(resp_valid), 32'(0));
      check("idle_div_start", 32'(div_start), 32'(0));
      g = -1;
      for (int k = 0; k < N_REQ; k++) begin
        int i;
        i = (mptr + k) % N_REQ;
        if (g < 0 && req_valid[i]) g = i;
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("grant", 32'(req_ready), 32'(exp_rdy));
      ag = -1;
      for (int i = 0; i < N_REQ; i++) if (ag < 0 && req_ready[i]) ag = i;
      if (ag >= 0) accept(ag);
    end
  endtask

  initial forever begin
    @(negedge clock);
    agent_step();
  end

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((ops.size() != 0 || outstanding || req_valid != '0) && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("drain_in_budget", 32'(n < budget), 32'(1));
    repeat (2) @(negedge clock);
    #2;
  endtask

  task automatic push(input int id, input logic [31:0] a, input logic [31:0] b);
    op_t o;
    o.id = id; o.a = a; o.b = b;
    ops.push_back(o);
  endtask

  task automatic check_order(input string tag, input int exp0, input int exp1,
                             input int exp2, input int exp3, input int n);
    int e[4];
    e = '{exp0, exp1, exp2, exp3};
    check({tag, "_count"}, 32'(served.size()), 32'(n));
    for (int k = 0; k < n && k < served.size(); k++) check(tag, 32'(served[k]), 32'(e[k]));
  endtask

  initial begin
    // Contention from reset: both requesters valid while reset is held.
    push(0, -32'sd100, 32'sd7);
    push(1, 32'sd7, -32'sd2);
    repeat (2) @(negedge clock);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'(0));
    check("rst_resp_valid", 32'(resp_valid), 32'(0));
    check("rst_div_start", 32'(div_start), 32'(0));
    check("rst_resp_q", resp_q, 32'(0));
    check("rst_resp_r", resp_r, 32'(0));
    check("rst_resp_id", 32'(resp_id), 32'(0));
    check("rst_resp_dz", 32'(resp_dz), 32'(0));
    check("rst_resp_err", 32'(resp_err), 32'(0));
    check("rst_div_dividend", div_dividend, 32'(0));
    check("rst_div_divisor", div_divisor, 32'(0));
    @(posedge clock);
    #2 reset_n = 1'b1;
    drain(400);
    check_order("contention_order", 0, 1, 0, 0, 2);

    served.delete();
    push(0, 32'sd11, 32'sd3);
    push(1, -32'sd20, 32'sd6);
    push(0, -32'sd5, -32'sd5);
    push(1, 32'sd9, 32'sd10);
    drain(600);
    check_order("fair_order", 0, 1, 0, 1, 4);

    push(0, 32'sd100, -32'sd7);
    drain(300);
    push(1, 32'sd55, 32'sd0);
    drain(100);
    push(0, 32'h8000_0000, 32'hFFFF_FFFF);
    drain(300);

    // Backpressure: every response held 10 cycles with the other requester waiting.
    hold_cfg = 10;
    push(0, 32'sd77, 32'sd5);
    push(1, 32'sd3, 32'sd9);
    drain(600);
    hold_cfg = -1;

    stuck = 1'b1;
    push(1, 32'sd1234, 32'sd5);
    push(0, -32'sd8, 32'sd0);
    drain(600);
    stuck = 1'b0;

    for (int k = 0; k < 40; k++) begin
      op_t o;
      o.id = int'($urandom_range(0, N_REQ - 1));
      o.a  = $urandom;
      o.b  = $urandom;
      case ($urandom_range(0, 7))
        0: o.b = '0;
        1: begin o.a = 32'h8000_0000; o.b = 32'hFFFF_FFFF; end
        2: o.b = 32'($urandom_range(1, 9));
        3: o.b = ~32'($urandom_range(0, 8));
        default: ;
      endcase
      ops.push_back(o);
    end
    drain(8000);

    // Reset mid-RUN at E0+10, then a fresh pair must start from requester 0.
    push(0, 32'sd1000, 32'sd3);
    while (!outstanding) @(posedge clock);
    repeat (10) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_resp_valid", 32'(resp_valid), 32'(0));
    check("midrst_div_start", 32'(div_start), 32'(0));
    check("midrst_req_ready", 32'(req_ready), 32'(0));
    ops.delete();
    served.delete();
    push(1, 32'sd50, 32'sd7);
    push(0, -32'sd9, 32'sd4);
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b1;
    drain(400);
    check_order("post_reset_order", 0, 1, 0, 0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/div_sched.md
Name: div_sched

Overview:
- Sequencer and arbiter that shares one iterative 32-bit signed divider among N_REQ requesters.
- Accepts one request at a time and selects among requesters round-robin.
- Drives the divider's start pulse and stable operands, waits for busy to fall, then returns quotient and remainder on a single tagged response channel.
- Handles divide-by-zero without using the divider, and includes a watchdog for a hung divider.

Parameters:
- N_REQ, 2, number of requesters (2..4)
- TIMEOUT, 48, maximum cycles in RUN before an error response
- IDW, 2, width of resp_id (at least clog2(N_REQ))

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester accept, one-hot or zero
- req_dividend  in  32*N_REQ  packed signed dividends, requester i in bits [32i+31:32i]
- req_divisor  in  32*N_REQ  packed signed divisors
- resp_valid  out  1  response valid
- resp_ready  in  1  response accept
- resp_id  out  IDW  index of the requester being answered
- resp_q  out  32  signed quotient
- resp_r  out  32  signed remainder
- resp_dz  out  1  divide-by-zero flag
- resp_err  out  1  watchdog timeout flag
- div_dividend  out  32  operand to divider, held for the whole operation
- div_divisor  out  32  operand to divider, held for the whole operation
- div_start  out  1  start pulse to divider
- div_busy  in  1  divider busy
- div_q  in  32  divider quotient
- div_r  in  32  divider remainder

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE.
  - req_ready=0, resp_valid=0, div_start=0.
  - All data outputs 0.
  - RR pointer set so requester 0 has top priority.
  - resp_dz=0, resp_err=0.
- The divider's own active-high reset is driven by the top level from ~reset_n.
- States: IDLE, START, LAUNCH, RUN, RESP.
- IDLE:
  - req_ready is combinational: one-hot grant to the first valid requester at or after the RR pointer.
  - On handshake edge E0 (req_valid[i] & req_ready[i]): latch operands and id, and advance the RR pointer to i+1 mod N_REQ.
  - If divisor==0: go to RESP with resp_q=32'hFFFFFFFF, resp_r=dividend, resp_dz=1; no div_start. resp_valid is high after E0.
  - Else: go to START.
- START: div_start=1 for exactly one cycle, then go to LAUNCH.
- LAUNCH:
  - div_start=0.
  - The divider latches operands on the falling start (its 1->0 start detection) at this edge.
  - Go to RUN; the watchdog counter is cleared.
- RUN:
  - Each edge, increment the watchdog.
  - If div_busy sampled 0: capture div_q/div_r into resp_q/resp_r, set dz=0 and err=0, go to RESP.
  - Else if the watchdog reaches TIMEOUT: resp_q=0, resp_r=0, resp_err=1, go to RESP.
- RESP:
  - resp_valid=1; data held stable until resp_ready.
  - On resp_valid & resp_ready, go to IDLE.
  - A new request is not accepted in the same cycle; req_ready=0 outside IDLE.
- Latency with a 32-iteration divider: accept edge E0 → resp_valid high after edge E0+35. Divide-by-zero: high after E0.
- div_dividend/div_divisor change only at an accept edge.
- Arithmetic is pure pass-through; 0x80000000 / -1 returns the divider's result (q=0x80000000, r=0) without a flag.
- Simultaneous requests: exactly one grant; the other requester keeps req_valid and is served next.
- A requester must hold req_valid and its operands until accepted.
- req_valid deasserting before grant: no effect.
- Reset mid-RUN: immediate IDLE with no response; the divider is reset by the same source.

Decomposition:
- Package div_sched_pkg holds:
  - the state enum (IDLE, START, LAUNCH, RUN, RESP)
  - DZ_QUOTIENT = 32'hFFFFFFFF
  - the default TIMEOUT
- Sub-module rr_arbiter (parameter N):
  - inputs: req, ptr
  - outputs: one-hot grant, next_ptr
  - purely combinational

Test Plan:
- Single request: req0 100 / -7 with a real divider attached → resp_valid at E0+35, resp_id=0, q=-14 (32'hFFFFFFF2), r=2, dz=0, err=0; div_start high exactly one cycle.
- Contention: req0 and req1 both valid from reset with (-100,7) and (7,-2) → req0 first (q=-14, r=-2), then req1 (q=-3, r=1).
- Fairness: req0 and req1 continuously valid for 4 operations → grants alternate 0,1,0,1.
- Divide-by-zero: req1 (55, 0) → resp_valid one cycle after accept with q=FFFFFFFF, r=55, dz=1; div_start never asserts.
- Backpressure and timeout:
  - Hold resp_ready=0 for 10 cycles → resp data stable, req_ready=0 throughout.
  - Stub divider with div_busy stuck at 1 → resp_err=1, q=r=0 after TIMEOUT cycles in RUN.
- Reset mid-RUN: reset_n low at E0+10 → resp_valid and div_start 0 immediately. After release, a new request completes normally with the RR pointer back at requester 0.
